// File: rtl/ir_command_decoder_pkg.sv
// Shared types and constants for the IR command decoder.
// Frame layout: 4-bit command (LSB first) followed by its bitwise inverse.
package ir_command_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEADER,
        SPACE,
        MARK,
        CHECK,
        STOP
    } ir_state_t;

    localparam int unsigned IR_CMD_BLOCK_BIT = 0;
    localparam int unsigned IR_CMD_LUNGE_BIT = 1;
    localparam int unsigned IR_FRAME_BITS    = 8;

    // Command must match its inverse, use only the low two bits, and not set both actions.
    function automatic logic ir_frame_good(input logic [IR_FRAME_BITS-1:0] frame);
        return (frame[3:0] == ~frame[7:4]) &&
               (frame[3:2] == 2'b00) &&
               (frame[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/ir_command_decoder_input_sync.sv
// Two-flop synchronizer for the IR line plus registered rise/fall detection.
// Edge flags assert in the same cycle the synchronized level first shows the new value.
module ir_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic stage;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            stage <= 1'b1;
            sync  <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= raw;
            stage <= meta;
            sync  <= stage;
            rise  <= stage & ~sync;
            fall  <= ~stage & sync;
        end
    end

endmodule

// File: rtl/ir_command_decoder.sv
// Pulse-distance IR frame decoder producing block/lunge commands.
// One FSM times marks and spaces on the synchronized line and validates each 8-bit frame.
module ir_command_decoder
    import ir_command_decoder_pkg::*;
#(
    parameter int unsigned LEADER_MIN = 600000,
    parameter int unsigned BIT_THRESH = 83160,
    parameter int unsigned TIMEOUT    = 371250,
    parameter int unsigned COUNT_W    = 20
) (
    input  logic clk_pixel_in,
    input  logic rst_in,
    input  logic ir_raw_in,
    output logic block_out,
    output logic lunge_out,
    output logic ir_valid_out,
    output logic frame_error_out
);

    logic                     line_sync;
    logic                     line_rise;
    logic                     line_fall;
    ir_state_t                state;
    logic [COUNT_W-1:0]       cnt;
    logic [IR_FRAME_BITS-1:0] shreg;
    logic [2:0]               bit_idx;
    logic                     first;

    ir_input_sync u_sync (
        .clk   (clk_pixel_in),
        .rst_n (rst_in),
        .raw   (ir_raw_in),
        .sync  (line_sync),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            cnt             <= '0;
            shreg           <= '0;
            bit_idx         <= '0;
            first           <= 1'b0;
            block_out       <= 1'b0;
            lunge_out       <= 1'b0;
            ir_valid_out    <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            ir_valid_out    <= 1'b0;
            frame_error_out <= 1'b0;
            if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (line_fall) begin
                        state <= LEADER;
                        cnt   <= COUNT_W'(1);
                    end
                end
                LEADER: begin
                    if (line_rise) begin
                        cnt <= COUNT_W'(1);
                        if (cnt >= COUNT_W'(LEADER_MIN)) begin
                            state   <= SPACE;
                            first   <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                SPACE: begin
                    // Timeout is tested first so it wins over a coincident fall.
                    if (cnt > COUNT_W'(TIMEOUT)) begin
                        frame_error_out <= 1'b1;
                        state           <= IDLE;
                    end else if (line_fall) begin
                        cnt <= COUNT_W'(1);
                        if (first) begin
                            first <= 1'b0;
                            state <= MARK;
                        end else begin
                            shreg   <= {(cnt >= COUNT_W'(BIT_THRESH)), shreg[IR_FRAME_BITS-1:1]};
                            bit_idx <= bit_idx + 3'd1;
                            state   <= (bit_idx == 3'(IR_FRAME_BITS - 1)) ? CHECK : MARK;
                        end
                    end
                end
                MARK: begin
                    if (cnt > COUNT_W'(TIMEOUT)) begin
                        frame_error_out <= 1'b1;
                        state           <= IDLE;
                    end else if (line_rise) begin
                        cnt   <= COUNT_W'(1);
                        state <= SPACE;
                    end
                end
                CHECK: begin
                    if (ir_frame_good(shreg)) begin
                        block_out    <= shreg[IR_CMD_BLOCK_BIT];
                        lunge_out    <= shreg[IR_CMD_LUNGE_BIT];
                        ir_valid_out <= 1'b1;
                    end else begin
                        frame_error_out <= 1'b1;
                    end
                    state <= STOP;
                end
                STOP: begin
                    if (line_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_command_decoder.sv
// Self-checking bench for ir_command_decoder: frames are described as line segments
// and a segment-level decoder model predicts pulses and held outputs.
module tb_ir_command_decoder;

    localparam int unsigned LMIN = 40;
    localparam int unsigned BT   = 10;
    localparam int unsigned TO   = 30;

    typedef struct {
        logic        lvl;
        int unsigned dur;
    } seg_t;

    logic clk_pixel_in = 1'b0;
    logic rst_in       = 1'b0;
    logic ir_raw_in    = 1'b1;
    logic block_out;
    logic lunge_out;
    logic ir_valid_out;
    logic frame_error_out;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    int          valid_cnt   = 0;
    int          err_cnt     = 0;
    int          both_cnt    = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned last_err_cyc   = 0;

    seg_t        segs[$];
    int unsigned seg_cyc[$];
    int          exp_valid;
    int          exp_err;
    logic        exp_block = 1'b0;
    logic        exp_lunge = 1'b0;

    ir_command_decoder #(
        .LEADER_MIN (LMIN),
        .BIT_THRESH (BT),
        .TIMEOUT    (TO),
        .COUNT_W    (20)
    ) dut (
        .clk_pixel_in    (clk_pixel_in),
        .rst_in          (rst_in),
        .ir_raw_in       (ir_raw_in),
        .block_out       (block_out),
        .lunge_out       (lunge_out),
        .ir_valid_out    (ir_valid_out),
        .frame_error_out (frame_error_out)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    always @(posedge clk_pixel_in) cyc <= cyc + 1;

    always @(negedge clk_pixel_in) begin
        if (ir_valid_out) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_error_out) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (ir_valid_out && frame_error_out) both_cnt <= both_cnt + 1;
    end

    // Standard frame: leader, leader space, 8 x (mark, space), stop mark, idle tail.
    task automatic build_frame(input logic [3:0] cmd, input logic [3:0] inv, input bit jitter);
        logic [7:0] bits;
        bits = {inv, cmd};
        segs.delete();
        segs.push_back('{1'b0, jitter ? $urandom_range(36, 60) : 45});
        segs.push_back('{1'b1, jitter ? $urandom_range(5, 28) : 20});
        for (int i = 0; i < 8; i++) begin
            segs.push_back('{1'b0, jitter ? $urandom_range(3, 8) : 5});
            if (bits[i]) segs.push_back('{1'b1, jitter ? $urandom_range(10, 25) : 15});
            else         segs.push_back('{1'b1, jitter ? $urandom_range(3, 9) : 5});
        end
        segs.push_back('{1'b0, 5});
        segs.push_back('{1'b1, 60});
    endtask

    // Decodes the segment list from durations alone.
    task automatic model_segs();
        int p = 0;
        bit first = 0;
        int n = 0;
        int val = 0;
        int cmd;
        int inv;
        exp_valid = 0;
        exp_err   = 0;
        foreach (segs[i]) begin
            case (p)
                0: if (!segs[i].lvl && segs[i].dur >= LMIN) begin
                       p = 1; first = 1; n = 0; val = 0;
                   end
                1: if (segs[i].dur > TO) begin
                       exp_err++; p = 0;
                   end else if (first) begin
                       first = 0; p = 2;
                   end else begin
                       if (segs[i].dur >= BT) val += (1 << n);
                       n++;
                       if (n == 8) begin
                           cmd = val % 16;
                           inv = val / 16;
                           if (cmd + inv == 15 && cmd < 3) begin
                               exp_valid++;
                               exp_block = (cmd % 2) == 1;
                               exp_lunge = (cmd / 2) == 1;
                           end else begin
                               exp_err++;
                           end
                           p = 3;
                       end else begin
                           p = 2;
                       end
                   end
                2: if (segs[i].dur > TO) begin
                       exp_err++; p = 0;
                   end else begin
                       p = 1;
                   end
                default: if (segs[i].lvl) p = 0;
            endcase
        end
    endtask

    task automatic apply_segs();
        seg_cyc.delete();
        foreach (segs[i]) begin
            ir_raw_in = segs[i].lvl;
            seg_cyc.push_back(cyc);
            repeat (segs[i].dur) @(negedge clk_pixel_in);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_pixel_in);
        vectors++;
        if ({block_out, lunge_out, ir_valid_out, frame_error_out} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {block_out, lunge_out, ir_valid_out, frame_error_out});
        end
        rst_in = 1'b1;
        repeat (10) @(negedge clk_pixel_in);
        vectors++;
        if (valid_cnt + err_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_idle_pulses: got %0d expected 0", valid_cnt + err_cnt);
        end
    endtask

    // Runs the current segment list and compares pulse counts and held outputs.
    task automatic run_and_check(input string name);
        int v0;
        int e0;
        int b0;
        v0 = valid_cnt; e0 = err_cnt; b0 = both_cnt;
        model_segs();
        apply_segs();
        vectors++;
        if (valid_cnt - v0 !== exp_valid) begin
            miscompares++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, valid_cnt - v0, exp_valid);
        end
        vectors++;
        if (err_cnt - e0 !== exp_err) begin
            miscompares++;
            $display("FAIL %s error_count: got %0d expected %0d", name, err_cnt - e0, exp_err);
        end
        vectors++;
        if ({block_out, lunge_out} !== {exp_block, exp_lunge}) begin
            miscompares++;
            $display("FAIL %s block_lunge: got %b%b expected %b%b", name,
                     block_out, lunge_out, exp_block, exp_lunge);
        end
        vectors++;
        if (both_cnt - b0 !== 0) begin
            miscompares++;
            $display("FAIL %s both_pulses: got %0d expected 0", name, both_cnt - b0);
        end
    endtask

    task automatic test_lunge_frame();
        build_frame(4'b0010, 4'b1101, 0);
        run_and_check("lunge");
        vectors++;
        if (last_valid_cyc !== seg_cyc[18] + 5) begin
            miscompares++;
            $display("FAIL lunge_latency: got cycle %0d expected %0d", last_valid_cyc, seg_cyc[18] + 5);
        end
        repeat (20) @(negedge clk_pixel_in);
        vectors++;
        if ({block_out, lunge_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL lunge_hold: got %b%b expected 01", block_out, lunge_out);
        end
    endtask

    task automatic test_block_neutral();
        build_frame(4'b0001, 4'b1110, 0);
        run_and_check("block");
        build_frame(4'b0000, 4'b1111, 0);
        run_and_check("neutral");
    endtask

    task automatic test_bad_frames();
        build_frame(4'b0001, 4'b0000, 0);
        run_and_check("bad_inverse");
        build_frame(4'b0011, 4'b1100, 0);
        run_and_check("both_bits");
    endtask

    task automatic test_glitches();
        segs.delete();
        segs.push_back('{1'b0, 20});
        segs.push_back('{1'b1, 60});
        run_and_check("short_leader");
        segs.delete();
        segs.push_back('{1'b0, 3});
        segs.push_back('{1'b1, 60});
        run_and_check("glitch");
        build_frame(4'b0010, 4'b1101, 0);
        run_and_check("after_glitch");
    endtask

    task automatic test_timeouts();
        build_frame(4'b0001, 4'b1110, 0);
        segs[9].dur = 31;
        run_and_check("space_timeout");
        vectors++;
        if (last_err_cyc !== seg_cyc[9] + 35) begin
            miscompares++;
            $display("FAIL space_timeout_time: got cycle %0d expected %0d", last_err_cyc, seg_cyc[9] + 35);
        end
        build_frame(4'b0010, 4'b1101, 0);
        segs[6].dur = 31;
        run_and_check("mark_timeout");
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        int e0;
        build_frame(4'b0010, 4'b1101, 0);
        run_and_check("pre_reset");
        build_frame(4'b0001, 4'b1110, 0);
        v0 = valid_cnt; e0 = err_cnt;
        for (int i = 0; i < 13; i++) begin
            ir_raw_in = segs[i].lvl;
            repeat (segs[i].dur) @(negedge clk_pixel_in);
        end
        ir_raw_in = 1'b1;
        repeat (3) @(negedge clk_pixel_in);
        rst_in = 1'b0;
        @(negedge clk_pixel_in);
        rst_in = 1'b1;
        repeat (60) @(negedge clk_pixel_in);
        exp_block = 1'b0;
        exp_lunge = 1'b0;
        vectors++;
        if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_pulses: got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0));
        end
        vectors++;
        if ({block_out, lunge_out} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b%b expected 00", block_out, lunge_out);
        end
        build_frame(4'b0001, 4'b1110, 0);
        run_and_check("post_reset");
    endtask

    task automatic test_random();
        logic [3:0] cmd;
        logic [3:0] inv;
        for (int k = 0; k < 16; k++) begin
            cmd = 4'($urandom_range(0, 15));
            inv = ($urandom_range(0, 2) != 0) ? ~cmd : 4'($urandom_range(0, 15));
            build_frame(cmd, inv, 1);
            run_and_check("random");
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_pixel_in);
        test_reset();
        test_lunge_frame();
        test_block_neutral();
        test_bad_frames();
        test_glitches();
        test_timeouts();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
